// File: rtl/deser_pkg.sv
// Shared slot encoding for the serializer/deserializer pair; must stay in
// step with the mux controller's slot walk.
package deser_pkg;

  typedef enum logic [1:0] {
    SLOT_0 = 2'b00,
    SLOT_1 = 2'b01,
    SLOT_2 = 2'b10,
    SLOT_3 = 2'b11
  } slottype;

  localparam int unsigned SLOTS = 4;

endpackage

// File: rtl/slot_counter.sv
// Rotating slot state SLOT_0..SLOT_3; advances on an accepted word, and a
// sync accept restarts the frame so the next word lands in SLOT_1.
module slot_counter
  import deser_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_advance,
  input  logic    i_sync,
  output slottype o_slot
);

  slottype r_state;
  slottype w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SLOT_0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_advance) begin
      if (i_sync) begin
        w_next = SLOT_1;
      end else begin
        case (r_state)
          SLOT_0:  w_next = SLOT_1;
          SLOT_1:  w_next = SLOT_2;
          SLOT_2:  w_next = SLOT_3;
          default: w_next = SLOT_0;
        endcase
      end
    end
  end

  always_comb o_slot = r_state;

endmodule

// File: rtl/frame_deserializer.sv
// Collects four serial words into one frame behind a valid/ready port.
// Define FRAME_SYNC_EN to add the in_first frame-sync input.
module frame_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned W = 8
) (
`ifdef FRAME_SYNC_EN
  input  logic                 in_first,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [SLOTS*W-1:0]   out_data,
  input  logic                 out_ready,
  output logic [1:0]           slot,
  output logic                 frame_start
);

  slottype            w_slot;
  logic               w_accept;
  logic               w_sync;
  logic               w_load;
  logic [W-1:0]       r_fill0;
  logic [W-1:0]       r_fill1;
  logic [W-1:0]       r_fill2;
  logic [SLOTS*W-1:0] r_out_data;
  logic               r_out_valid;

`ifdef FRAME_SYNC_EN
  assign w_sync = in_first;
`else
  assign w_sync = 1'b0;
`endif

  // Only the 4th word can be blocked, and only by an undelivered frame.
  assign in_ready = ~((w_slot == SLOT_3) & r_out_valid & ~out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept & ~w_sync & (w_slot == SLOT_3);

  slot_counter u_slot_counter (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_accept),
    .i_sync    (w_sync),
    .o_slot    (w_slot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill0 <= '0;
      r_fill1 <= '0;
      r_fill2 <= '0;
    end else if (w_accept) begin
      if (w_sync) begin
        r_fill0 <= in_data;
        r_fill1 <= '0;
        r_fill2 <= '0;
      end else begin
        case (w_slot)
          SLOT_0:  r_fill0 <= in_data;
          SLOT_1:  r_fill1 <= in_data;
          SLOT_2:  r_fill2 <= in_data;
          default: ;
        endcase
      end
    end
  end

  // A load in the same cycle as a drain wins, keeping out_valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {in_data, r_fill2, r_fill1, r_fill0};
    end else if (r_out_valid & out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign slot        = w_slot;
  assign frame_start = (w_slot == SLOT_0);

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: vector table, directed corner
// sequences and randomized traffic against a queue-based frame model.
module tb_frame_deserializer;

  localparam int unsigned W = 8;
`ifdef FRAME_SYNC_EN
  localparam bit SYNC = 1'b1;
  logic in_first;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [4*W-1:0] out_data;
  logic           out_ready;
  logic [1:0]     slot;
  logic           frame_start;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  frame_deserializer #(.W(W)) dut (
`ifdef FRAME_SYNC_EN
    .in_first    (in_first),
`endif
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .slot        (slot),
    .frame_start (frame_start)
  );

  // Reference: words of the partial frame in a queue, plus the held frame.
  logic [W-1:0]   pend[$];
  logic           m_valid;
  logic [4*W-1:0] m_frame;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        rdy;
    logic [1:0]  sl;
    logic        ov;
    logic        cd;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready(input logic r);
    return !(pend.size() == 3 && m_valid && !r);
  endfunction

  task automatic model_reset();
    pend.delete();
    m_valid = 1'b0;
    m_frame = '0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    logic acc;
    logic newf;
    acc  = v && m_ready(r);
    newf = 1'b0;
    if (acc) begin
      if (SYNC && f) pend.delete();
      pend.push_back(d);
      if (pend.size() == 4) begin
        m_frame = {pend[3], pend[2], pend[1], pend[0]};
        pend.delete();
        newf = 1'b1;
      end
    end
    if (newf) m_valid = 1'b1;
    else if (m_valid && r) m_valid = 1'b0;
  endtask

  task automatic compare_model();
    check("m_in_ready", in_ready, m_ready(out_ready));
    check("m_slot", slot, pend.size());
    check("m_frame_start", frame_start, pend.size() == 0);
    check("m_out_valid", out_valid, m_valid);
    if (m_valid) check("m_out_data", out_data, m_frame);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef FRAME_SYNC_EN
    in_first  = f;
`endif
    #1;
    compare_model();
    model_step(v, d, r, f);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_slot"}, slot, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_frame_start"}, frame_start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check_reset_vals("rst");
    model_reset();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FRAME_SYNC_EN
    in_first  = 1'b0;
`endif
    model_reset();
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // Streaming with out_ready high: values observed before each edge.
    tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 8'h02, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 8'h04, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 8'h05, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 32'h04030201};
    tbl[5] = '{1'b1, 8'h06, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 8'h08, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h08070605};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h08070605};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      check("tbl_in_ready", in_ready, tbl[i].rdy);
      check("tbl_slot", slot, tbl[i].sl);
      check("tbl_frame_start", frame_start, tbl[i].sl == 2'd0);
      check("tbl_out_valid", out_valid, tbl[i].ov);
      if (tbl[i].cd) check("tbl_out_data", out_data, tbl[i].od);
    end

    // Backpressure: 4th word of the next frame stalls until out_ready.
    do_reset();
    for (int k = 1; k <= 4; k++) drive(1'b1, 8'(k), 1'b1, 1'b0);
    for (int k = 5; k <= 7; k++) drive(1'b1, 8'(k), 1'b0, 1'b0);
    drive(1'b1, 8'h08, 1'b0, 1'b0);
    check("bp_stall_ready", in_ready, 0);
    check("bp_stall_data", out_data, 32'h04030201);
    drive(1'b1, 8'h08, 1'b0, 1'b0);
    check("bp_stall_ready2", in_ready, 0);
    drive(1'b1, 8'h08, 1'b1, 1'b0);
    check("bp_accept_ready", in_ready, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 32'h08070605);

    // Hold stability while new words keep filling behind the held frame.
    for (int i = 0; i < 10; i++) begin
      drive(i < 3, 8'h50 + 8'(i), 1'b0, 1'b0);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, 32'h08070605);
    end

    // Gaps: in_valid toggling; invalid words must be ignored.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) drive(1'b1, 8'h10 + 8'(i / 2), 1'b1, 1'b0);
      else            drive(1'b0, 8'hEE, 1'b1, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("gap_out_valid", out_valid, 1);
    check("gap_out_data", out_data, 32'h13121110);

    // Asynchronous reset mid-frame with a frame already held.
    do_reset();
    for (int k = 1; k <= 4; k++) drive(1'b1, 8'(k), 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("async_out_valid", out_valid, 1);
    check("async_out_data", out_data, 32'hA3A2A1A0);

`ifdef FRAME_SYNC_EN
    // Frame sync restarts alignment; the partial 0x31/0x32 frame is lost.
    do_reset();
    drive(1'b1, 8'h31, 1'b1, 1'b0);
    drive(1'b1, 8'h32, 1'b1, 1'b0);
    drive(1'b1, 8'h40, 1'b1, 1'b1);
    check("sync_slot_at_first", slot, 2);
    drive(1'b1, 8'h41, 1'b1, 1'b0);
    check("sync_slot_after", slot, 1);
    drive(1'b1, 8'h42, 1'b1, 1'b0);
    drive(1'b1, 8'h43, 1'b1, 1'b0);
    check("sync_no_early_frame", out_valid, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("sync_out_valid", out_valid, 1);
    check("sync_out_data", out_data, 32'h43424140);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
